// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60) and the pixel-period phase encoding
// used by the framebuffer arbiter.
package vga_pkg;

    localparam int H_RES   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;

    localparam int V_RES   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    typedef logic [1:0] phase_t;

    // Phase 0 is the display read slot, phase 1 captures the read data,
    // phase 3 is where the counter parks when the pixel enable stops.
    localparam phase_t PH_DISP = 2'd0;
    localparam phase_t PH_CAPT = 2'd1;
    localparam phase_t PH_LAST = 2'd3;

endpackage

// File: rtl/wr_fifo.sv
// Synchronous FIFO buffering host writes; head is visible on rdata while not
// empty and there is no fall-through from push to pop.
module wr_fifo #(
    parameter  int WIDTH = 27,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: one display read slot per pixel period, every
// other RAM cycle drains the buffered host write queue.
module vram_arbiter
    import vga_pkg::*;
#(
    parameter  int H_RES      = vga_pkg::H_RES,
    parameter  int ADDR_W     = 19,
    parameter  int DATA_W     = 8,
    parameter  int FIFO_DEPTH = 4,
    localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_ce,
    input  logic              draw,
    input  logic [9:0]        pix,
    input  logic [9:0]        line,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic [LW-1:0]     fifo_level
);

    phase_t                     phase;
    logic                       rd_pend;
    logic                       disp_slot;
    logic                       host_pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [ADDR_W+DATA_W-1:0]   head;
    logic [ADDR_W-1:0]          head_addr;
    logic [DATA_W-1:0]          head_data;
    logic [ADDR_W-1:0]          disp_addr;
    logic [ADDR_W-1:0]          addr_hold;
    logic [DATA_W-1:0]          wdata_hold;

    wr_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_valid),
        .pop   (host_pop),
        .wdata ({wr_addr, wr_data}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign {head_addr, head_data} = head;
    assign wr_ready = !fifo_full;

    // Constant-coefficient multiply; reduces to shifts and adds.
    assign disp_addr = ADDR_W'(line) * ADDR_W'(H_RES) + ADDR_W'(pix);

    assign disp_slot = (phase == PH_DISP) && draw;
    assign host_pop  = !disp_slot && !fifo_empty;

    always_comb begin
        mem_addr  = addr_hold;
        mem_wdata = wdata_hold;
        mem_we    = 1'b0;
        if (disp_slot) begin
            mem_addr = disp_addr;
        end else if (host_pop) begin
            mem_addr  = head_addr;
            mem_wdata = head_data;
            mem_we    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase      <= PH_LAST;
            rd_pend    <= 1'b0;
            addr_hold  <= '0;
            wdata_hold <= '0;
            pix_data   <= '0;
        end else begin
            if (pix_ce)
                phase <= PH_DISP;
            else if (phase != PH_LAST)
                phase <= phase + 1'b1;
            rd_pend    <= disp_slot;
            addr_hold  <= mem_addr;
            wdata_hold <= mem_wdata;
            // Read data arrives the cycle after the display slot; otherwise blank.
            if (rd_pend)
                pix_data <= mem_rdata;
            else if (phase == PH_CAPT)
                pix_data <= '0;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized scoreboard bench for vram_arbiter with a behavioural RAM and a
// queue-based model of the host write path and pixel slot rules.
module tb_vram_arbiter;
    import vga_pkg::*;

    localparam int ADDR_W     = 19;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int LW         = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pix_ce = 1'b0;
    logic              draw = 1'b0;
    logic [9:0]        pix = '0;
    logic [9:0]        line = '0;
    logic              wr_valid = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [DATA_W-1:0] pix_data;
    logic [LW-1:0]     fifo_level;

    int  n_chk = 0;
    int  n_fail = 0;
    wr_t exp_wr[$];

    always #5 clk = ~clk;

    vram_arbiter #(
        .H_RES      (H_RES),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_ce     (pix_ce),
        .draw       (draw),
        .pix        (pix),
        .line       (line),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .pix_data   (pix_data),
        .fifo_level (fifo_level)
    );

    // Read-first single-port RAM, aliased onto 4K words; filled during reset.
    logic [DATA_W-1:0] ram [4096];
    logic [12:0]       init_cnt = '0;

    always @(posedge clk) begin
        if (init_cnt < 13'd4096) begin
            ram[init_cnt[11:0]] <= (init_cnt == 13'd1285) ? 8'hA5 : (init_cnt[7:0] ^ 8'h3C);
            init_cnt <= init_cnt + 13'd1;
        end else if (mem_we) begin
            ram[mem_addr[11:0]] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr[11:0]];
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: model state is "cycles since the last pixel enable"
    // plus the queue of accepted writes not yet seen on the RAM port.
    initial begin : monitor
        int                since;
        int                sz;
        logic              disp;
        logic              per_disp;
        logic [DATA_W-1:0] per_pix;
        logic [ADDR_W-1:0] ea;
        wr_t               w;
        since    = 3;
        per_disp = 1'b0;
        per_pix  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_wr.delete();
                since    = 3;
                per_disp = 1'b0;
            end else begin
                sz   = exp_wr.size();
                disp = (since == 0) && draw;
                check("mem_we", mem_we, (!disp && sz > 0));
                check("wr_ready", wr_ready, (sz != FIFO_DEPTH));
                check("fifo_level", fifo_level, sz);
                if (since == 0) begin
                    per_disp = disp;
                    per_pix  = '0;
                end
                if (disp) begin
                    ea = ADDR_W'(int'(line) * H_RES + int'(pix));
                    check("disp_addr", mem_addr, ea);
                    per_pix = ram[ea[11:0]];
                end
                if (since == 2)
                    check("pix_data", pix_data, per_disp ? per_pix : 8'h00);
                if (mem_we && sz > 0) begin
                    w = exp_wr.pop_front();
                    check("wr_addr", mem_addr, w.addr);
                    check("wr_data", mem_wdata, w.data);
                end
                if (wr_valid && sz != FIFO_DEPTH) begin
                    w.addr = wr_addr;
                    w.data = wr_data;
                    exp_wr.push_back(w);
                end
                since = pix_ce ? 0 : ((since < 3) ? since + 1 : 3);
            end
        end
    end

    task automatic one(input logic ce, input logic dr, input logic [9:0] px, input logic [9:0] ln,
                       input logic wv);
        pix_ce   = ce;
        draw     = dr;
        pix      = px;
        line     = ln;
        wr_valid = wv;
        wr_addr  = ADDR_W'($urandom);
        wr_data  = DATA_W'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic period(input int len, input logic dr, input logic [9:0] px, input logic [9:0] ln,
                          input int wr_pct);
        for (int k = 0; k < len; k++)
            one(k == len - 1, dr, px, ln, int'($urandom_range(0, 99)) < wr_pct);
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int guard;
        repeat (4100) @(posedge clk);
        #1;
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_pix_data", pix_data, 0);
        check("rst_wr_ready", wr_ready, 1);
        rst_n = 1'b1;

        // Fixed coordinate (line 2, pixel 5) reads word 1285.
        for (int p = 0; p < 3; p++) period(4, 1'b1, 10'd5, 10'd2, 0);
        check("pix_a5", pix_data, 8'hA5);

        // Continuous host pushes during active video.
        for (int p = 0; p < 8; p++) period(4, 1'b1, 10'(100 + p), 10'd7, 100);

        // Drain, then starve the host port so exactly three entries queue up.
        for (int c = 0; c < 10; c++) one(1'b0, 1'b0, 10'd0, 10'd0, 1'b0);
        for (int c = 0; c < 3; c++) one(1'b1, 1'b1, 10'(c), 10'd9, 1'b1);
        check("pre_rst_level", fifo_level, 3);
        pix_ce   = 1'b0;
        wr_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_ready", wr_ready, 1);
        check("mid_rst_we", mem_we, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_wdata", mem_wdata, 0);
        check("mid_rst_pix", pix_data, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int p = 0; p < 3; p++) period(4, 1'b1, 10'd20, 10'd3, 0);

        // Blanking with the pixel enable stopped: one write per cycle.
        for (int c = 0; c < 4; c++) one(1'b0, 1'b0, 10'd0, 10'd0, 1'b1);
        for (int c = 0; c < 4; c++) one(1'b0, 1'b0, 10'd0, 10'd0, 1'b0);

        // End of a visible line falling into blanking.
        for (int p = 637; p < 640; p++) period(4, 1'b1, 10'(p), 10'd5, 60);
        for (int p = 0; p < 3; p++) period(4, 1'b0, 10'd0, 10'd0, 80);

        // Randomized traffic with irregular pixel-enable spacing.
        for (int p = 0; p < 400; p++)
            period(int'($urandom_range(1, 6)), $urandom_range(0, 3) != 0,
                   10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)),
                   int'($urandom_range(0, 100)));

        guard = 0;
        while (exp_wr.size() > 0 && guard < 40) begin
            one(1'b0, 1'b0, 10'd0, 10'd0, 1'b0);
            guard++;
        end
        check("drain", exp_wr.size(), 0);
        one(1'b0, 1'b0, 10'd0, 10'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous video RAM between the VGA scan-out path and a host write port.
- Sits between the VGA timing generator (consumes its pixel clock-enable, DRAW, PIX and LINE) and the framebuffer RAM.
- Display reads own a fixed slot in every pixel period; buffered host writes fill all remaining RAM cycles.

Parameters:
- H_RES, 640, visible pixels per line (address stride)
- ADDR_W, 19, RAM address width (H_RES*V_RES must fit)
- DATA_W, 8, pixel/RAM data width
- FIFO_DEPTH, 4, host write FIFO entries (power of two, >=2)

Ports:
- CLK  in  1  system clock (RAM clock)
- RST_N  in  1  asynchronous active-low reset
- PIX_CE  in  1  one-cycle pixel clock-enable, the same pulse that advances the timing counters
- DRAW  in  1  visible-area flag from the timing generator
- PIX  in  10  visible column, valid while DRAW=1
- LINE  in  10  visible row, valid while DRAW=1
- WR_VALID  in  1  host write request
- WR_ADDR  in  ADDR_W  host write address
- WR_DATA  in  DATA_W  host write data
- WR_READY  out  1  FIFO can accept a write
- MEM_ADDR  out  ADDR_W  RAM address
- MEM_WE  out  1  RAM write enable
- MEM_WDATA  out  DATA_W  RAM write data
- MEM_RDATA  in  DATA_W  RAM read data, registered, 1-cycle latency
- PIX_DATA  out  DATA_W  pixel to DAC, 0 when blanked
- FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  entries currently queued

Behaviour:
- Reset (RST_N=0, asynchronous) forces phase=3, FIFO empty, WR_READY=1, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, PIX_DATA=0, FIFO_LEVEL=0, rd_pend=0. Reset mid-operation discards all queued writes.
- Phase counter (2 bit):
  - Cycle with PIX_CE=1: phase<=0.
  - Otherwise phase<=phase+1, saturating at 3.
  - Phase 0 is therefore the first cycle carrying new PIX/LINE values.
  - If PIX_CE stops, phase stays at 3 and every cycle is a host slot.
- Display slot: phase==0 && DRAW==1.
  - Drive MEM_ADDR = LINE*H_RES + PIX, truncated to ADDR_W. The multiply is by a constant; no runtime multiplier.
  - Drive MEM_WE=0 and set rd_pend<=1.
- Host slot: any cycle that is not a display slot, with FIFO non-empty.
  - Pop the FIFO head and drive MEM_ADDR, MEM_WDATA and MEM_WE=1 in that same cycle.
  - Otherwise MEM_WE=0.
  - MEM_ADDR and MEM_WDATA hold their last value when idle.
- All MEM_* outputs are combinational from the registered phase and FIFO head. They are glitch-free relative to CLK.
- Pixel capture:
  - In the cycle after a display slot (rd_pend=1), PIX_DATA<=MEM_RDATA and rd_pend<=0.
  - In phase 1 with no pending read, PIX_DATA<=0 (blanking).
  - PIX_DATA changes 2 CLK after the coordinate change and is stable for the rest of the pixel period.
- Host FIFO (sub-module):
  - WR_READY = (level != FIFO_DEPTH).
  - A push occurs when WR_VALID && WR_READY.
  - Push and pop in the same cycle: level unchanged, data ordering preserved.
  - When full, WR_READY=0 even if a pop occurs that cycle; no fall-through.
  - Writes reach RAM in acceptance order.
- Write bandwidth:
  - During DRAW: at least 3 host writes per 4-cycle pixel period.
  - During blanking: 1 write per cycle.
- Hazard: a host write to the address being scanned in the same pixel period is allowed. Display gets the old or new value depending on slot order; no stall.
- Address wrap: ADDR_W overflow truncates; no error flag.

Decomposition:
- Package vga_pkg holds H_RES/V_RES and the full H/V sync, porch and total constants, shared with the timing generator. It also holds the phase localparams PH_DISP=0 and PH_LAST=3.
- Sub-module wr_fifo: synchronous FIFO, parameterised width (ADDR_W+DATA_W) and depth, with the same CLK/RST_N, push/pop/full/empty/level ports.

Test Plan:
- Reset while FIFO holds 3 entries and DRAW=1 -> all outputs 0, WR_READY=1, FIFO_LEVEL=0 within the same cycle, no MEM_WE after release until a new push.
- PIX_CE every 4th cycle, DRAW=1, LINE=2, PIX=5 -> MEM_ADDR=1285, MEM_WE=0 in phase 0; RAM returns 0xA5 -> PIX_DATA=0xA5 from phase 2 on.
- Push 5 writes back-to-back with PIX_CE every 4th cycle and DRAW=1 -> WR_READY drops at level 4. No MEM_WE ever in phase 0. All 5 writes are issued in order, 3 per pixel period max.
- DRAW=0 and PIX_CE held low, 4 pushes -> phase saturates at 3 and writes issue on consecutive cycles, 1 cycle after each push.
- Simultaneous push and pop at level 2 -> level stays 2 and the popped entry is the oldest.
- DRAW falls (PIX=639 -> blank) -> PIX_DATA returns to 0 in phase 1 of the first blank pixel, and phase 0 becomes a host slot.
